// File: rtl/noc_packetizer_if.sv
// Descriptor, payload and flit-output handshake bundle for noc_packetizer.
// master = traffic source / mesh side, slave = the packetizer.
interface noc_packetizer_if #(
    parameter int unsigned LEN_W = 4
);
    logic [3:0]       msg_dest;
    logic [LEN_W-1:0] msg_len;
    logic             msg_valid;
    logic             msg_ready;
    logic [29:0]      pl_data;
    logic             pl_valid;
    logic             pl_ready;
    logic [31:0]      data_out;
    logic             valid_out;
    logic             ready_out;

    modport master (
        output msg_dest, msg_len, msg_valid, pl_data, pl_valid, ready_out,
        input  msg_ready, pl_ready, data_out, valid_out
    );

    modport slave (
        input  msg_dest, msg_len, msg_valid, pl_data, pl_valid, ready_out,
        output msg_ready, pl_ready, data_out, valid_out
    );
endinterface

// File: rtl/noc_packetizer.sv
// Wormhole packetizer: descriptor + payload stream -> head/body/tail flits, one per cycle.
// Optional NOC_PKT_STATS_EN adds a 16-bit count of transferred tail flits (pkt_count).
module noc_packetizer #(
    parameter logic [3:0]  SRC_ID = 4'd0,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_packetizer_if.slave      bus,
`ifdef NOC_PKT_STATS_EN
    output logic [15:0]          pkt_count,
`endif
    output logic                 busy
);
    typedef enum logic {StIdle, StPayload} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             free;

    assign free = !valid_q || bus.ready_out;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        data_d        = data_q;
        valid_d       = valid_q;
        bus.msg_ready = 1'b0;
        bus.pl_ready  = 1'b0;
        // A free register with nothing new loaded empties; a stalled one holds.
        if (free) begin
            valid_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                // Gated by rst so nothing is offered while reset is held.
                bus.msg_ready = free && rst;
                if (free && bus.msg_valid) begin
                    data_d  = {2'b01, 22'd0, SRC_ID, bus.msg_dest};
                    valid_d = 1'b1;
                    rem_d   = (bus.msg_len == '0) ? LEN_W'(1) : bus.msg_len;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                bus.pl_ready = free;
                if (free && bus.pl_valid) begin
                    valid_d = 1'b1;
                    if (rem_q != LEN_W'(1)) begin
                        data_d = {2'b10, bus.pl_data};
                        rem_d  = rem_q - LEN_W'(1);
                    end else begin
                        data_d  = {2'b11, bus.pl_data};
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign busy          = (state_q == StPayload) || valid_q;

`ifdef NOC_PKT_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (valid_q && bus.ready_out && data_q[31:30] == 2'b11) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign pkt_count = cnt_q;
`endif
endmodule

// File: tb/tb_noc_packetizer.sv
// Self-checking bench for noc_packetizer: directed scenarios plus randomized traffic
// scored against a flit-stream model built from each message's dest/len/payload.
module tb_noc_packetizer;
    localparam logic [3:0]  SRC = 4'h0;
    localparam int unsigned LW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
`ifdef NOC_PKT_STATS_EN
    logic [15:0] pkt_count;
`endif

    noc_packetizer_if #(.LEN_W(LW)) bus ();

    noc_packetizer #(.SRC_ID(SRC), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
`ifdef NOC_PKT_STATS_EN
        .pkt_count (pkt_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0]   exp_q[$];
    logic [31:0]   xfer_log[$];
    logic [3:0]    mq_dest[$];
    logic [LW-1:0] mq_len[$];
    logic [29:0]   pq[$];

    int   p_msg = 100;
    int   p_pl  = 100;
    int   p_rdy = 100;
    bit   bp_mode = 1'b0;
    bit   bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   cyc = 0;
    bit   stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic s_valid, s_ready;
    logic [31:0] s_data;

    logic [31:0] basic_exp[6] = '{32'h40000007, 32'h80000012, 32'h80000013,
                                  32'h80000014, 32'h80000015, 32'hC0000016};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue one message; the expected flits come straight from the packet rules.
    task automatic add_msg(input logic [3:0] dest, input logic [LW-1:0] len,
                           input logic [29:0] base, input bit rnd);
        int n;
        logic [29:0] w;
        n = (len == '0) ? 1 : int'(len);
        mq_dest.push_back(dest);
        mq_len.push_back(len);
        exp_q.push_back({2'b01, 22'd0, SRC, dest});
        for (int i = 0; i < n; i++) begin
            w = rnd ? 30'($urandom) : base + 30'(i);
            pq.push_back(w);
            exp_q.push_back({(i == n - 1) ? 2'b11 : 2'b10, w});
        end
    endtask

    task automatic drive();
        bus.msg_valid = 1'b0;
        bus.msg_dest  = '0;
        bus.msg_len   = '0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = '0;
        if (mq_dest.size() != 0) begin
            bus.msg_valid = int'($urandom_range(99)) < p_msg;
            bus.msg_dest  = mq_dest[0];
            bus.msg_len   = mq_len[0];
        end
        if (pq.size() != 0) begin
            bus.pl_valid = int'($urandom_range(99)) < p_pl;
            bus.pl_data  = pq[0];
        end
        bus.ready_out = bp_mode ? bp_pat[cyc % 4] : (int'($urandom_range(99)) < p_rdy);
    endtask

    // Sample settled outputs, score transfers, then advance one clock.
    task automatic tick();
        #1;
        s_valid = bus.valid_out;
        s_ready = bus.ready_out;
        s_data  = bus.data_out;
        if (stall_prev) begin
            check("stall_hold_valid", {31'd0, s_valid}, 32'd1);
            check("stall_hold_data", s_data, prev_data);
        end
        if (s_valid && !s_ready) begin
            check("stall_ready_low", {30'd0, bus.msg_ready, bus.pl_ready}, 32'd0);
        end
        if (s_valid) check("busy_while_valid", {31'd0, busy}, 32'd1);
        stall_prev = s_valid && !s_ready;
        prev_data  = s_data;
        if (s_valid && s_ready) begin
            xfer_log.push_back(s_data);
            if (exp_q.size() == 0) check("extra_flit", 32'(exp_q.size()), 32'd1);
            else check("flit", s_data, exp_q.pop_front());
        end
        if (bus.msg_valid && bus.msg_ready) begin
            void'(mq_dest.pop_front());
            void'(mq_len.pop_front());
        end
        if (bus.pl_valid && bus.pl_ready) void'(pq.pop_front());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int max_cyc, output int span);
        int first;
        int last;
        first = -1;
        last  = -1;
        for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) begin
            drive();
            tick();
            if (s_valid && first < 0) first = c;
            if (s_valid && s_ready) last = c;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        span = last - first + 1;
    endtask

    initial begin
        int span;
        int total;
        drive();
        @(negedge clk);

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            drive();
            #1;
            check("rst_data", bus.data_out, 32'd0);
            check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_rdy", {30'd0, bus.msg_ready, bus.pl_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        drive();
        #1;
        check("msg_ready_after_rst", {31'd0, bus.msg_ready}, 32'd1);

        // Basic packet: dest 7, len 5
        xfer_log.delete();
        add_msg(4'd7, 4'd5, 30'h12, 1'b0);
        run(50, span);
        check("basic_count", 32'(xfer_log.size()), 32'd6);
        check("basic_span", 32'(span), 32'd6);
        if (xfer_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("basic_flit_const", xfer_log[i], basic_exp[i]);
        end
        check("basic_idle_busy", {31'd0, busy}, 32'd0);

        // Single-word packet, len 1 then len 0
        for (int k = 0; k < 2; k++) begin
            xfer_log.delete();
            add_msg(4'd5, (k == 0) ? 4'd1 : 4'd0, 30'h21, 1'b0);
            run(20, span);
            check("single_count", 32'(xfer_log.size()), 32'd2);
            check("single_span", 32'(span), 32'd2);
            if (xfer_log.size() == 2) begin
                check("single_head", xfer_log[0], 32'h40000005);
                check("single_tail", xfer_log[1], 32'hC0000021);
            end
        end

        // Backpressure: ready_out cycles 1,0,0,1 through an 8-word packet
        xfer_log.delete();
        bp_mode = 1'b1;
        add_msg(4'hA, 4'd8, 30'h100, 1'b0);
        run(100, span);
        bp_mode = 1'b0;
        check("bp_count", 32'(xfer_log.size()), 32'd9);
        if (xfer_log.size() == 9) begin
            check("bp_head", xfer_log[0], 32'h4000000A);
            check("bp_tail", xfer_log[8], 32'hC0000107);
        end

        // Back-to-back packets with everything valid
        xfer_log.delete();
        add_msg(4'd8, 4'd3, 30'h31, 1'b0);
        add_msg(4'd3, 4'd2, 30'h41, 1'b0);
        run(40, span);
        check("b2b_count", 32'(xfer_log.size()), 32'd7);
        check("b2b_span", 32'(span), 32'd7);
        if (xfer_log.size() == 7) begin
            check("b2b_tail", xfer_log[3], 32'hC0000033);
            check("b2b_head", xfer_log[4], 32'h40000003);
        end

        // Reset after the second body flit
        xfer_log.delete();
        add_msg(4'h6, 4'd6, 30'h51, 1'b0);
        for (int c = 0; c < 50 && xfer_log.size() < 3; c++) begin
            drive();
            tick();
        end
        check("mid_progress", 32'(xfer_log.size()), 32'd3);
        check("mid_valid_before", {31'd0, bus.valid_out}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_valid_drop", {31'd0, bus.valid_out}, 32'd0);
        check("mid_busy_drop", {31'd0, busy}, 32'd0);
        exp_q.delete();
        mq_dest.delete();
        mq_len.delete();
        pq.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        xfer_log.delete();
        add_msg(4'h2, 4'd2, 30'h61, 1'b0);
        run(30, span);
        check("post_rst_count", 32'(xfer_log.size()), 32'd3);
        if (xfer_log.size() == 3) begin
            check("post_rst_head", xfer_log[0], 32'h40000002);
            check("post_rst_tail", xfer_log[2], 32'hC0000062);
        end
`ifdef NOC_PKT_STATS_EN
        check("pkt_count_after_trunc", {16'd0, pkt_count}, 32'd1);
`endif

        // Randomized traffic with random valids and backpressure
        xfer_log.delete();
        p_msg = 70;
        p_pl  = 65;
        p_rdy = 60;
        total = 0;
        for (int m = 0; m < 24; m++) begin
            logic [LW-1:0] len;
            len = LW'($urandom_range(15));
            total += ((len == '0) ? 1 : int'(len)) + 1;
            add_msg(4'($urandom_range(15)), len, 30'd0, 1'b1);
        end
        run(8000, span);
        check("rand_count", 32'(xfer_log.size()), 32'(total));
`ifdef NOC_PKT_STATS_EN
        check("pkt_count_final", {16'd0, pkt_count}, 32'd25);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Network-interface packetizer that sits directly upstream of a Mesh33 node input port (`NodeN_data_in` / `NodeN_valid_in` / `NodeN_ready_in`). It accepts a message descriptor (destination, length) and a stream of payload words. It emits a wormhole packet: one head flit, zero or more body flits, and one tail flit, in the mesh's 32-bit flit format. It replaces hand-sequenced flit generation at each traffic source and sustains one flit per cycle, with no bubbles between back-to-back packets.

## Interface
Parameters:
- `SRC_ID`, default 0: 4-bit source node ID inserted into every head flit.
- `LEN_W`, default 4: width of the payload-length field; maximum payload count is 2^LEN_W−1.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `msg_dest` in 4: destination node ID.
- `msg_len` in LEN_W: payload word count; 0 is coerced to 1.
- `msg_valid` in 1: descriptor valid.
- `msg_ready` out 1: descriptor accepted when high together with `msg_valid`.
- `pl_data` in 30: payload word.
- `pl_valid` in 1: payload valid.
- `pl_ready` out 1: payload accepted when high together with `pl_valid`.
- `data_out` out 32: flit to the node's `data_in`.
- `valid_out` out 1: flit valid, to the node's `valid_in`.
- `ready_out` in 1: from the node's `ready_in`.
- `busy` out 1: a packet is in progress or the output register is occupied.
- `pkt_count` out 16: present only with `NOC_PKT_STATS_EN`.

## Operation
Flit format:
- [31:30] carries the flit type: 01 = head, 10 = body, 11 = tail.
- Head flit: [29:8] = 0, [7:4] = SRC_ID, [3:0] = dest.
- Body and tail flits: [29:0] = payload word.

Datapath:
- A single output register (`data_out`, `valid_out`) holds the current flit.
- The output register is "free" when `!valid_out || ready_out`.
- A flit transfers on a rising edge where `valid_out && ready_out`.

FSM states:
- IDLE:
  - `msg_ready` = free.
  - On the descriptor handshake: latch `msg_dest`, load `rem` = max(`msg_len`, 1), load the head flit into the output register, and go to PAYLOAD.
- PAYLOAD:
  - `pl_ready` = free.
  - On a payload handshake with `rem` > 1: load a body flit and decrement `rem`.
  - On a payload handshake with `rem` == 1: load the tail flit and return to IDLE.
- `msg_ready` is 0 in PAYLOAD; `pl_ready` is 0 in IDLE.
- If the output register is free and nothing new is loaded, `valid_out` drops to 0 on that edge.
- `busy` = (state == PAYLOAD) || `valid_out`.
- A packet of N payload words produces exactly N+1 flits. For N = 1 the sequence is head followed by tail; there is no body flit.

Boundary conditions:
- Payload starvation in PAYLOAD: `valid_out` goes low after the current flit drains. No filler flit is ever inserted mid-packet.
- Backpressure (`valid_out && !ready_out`): `data_out` and `valid_out` hold stable. `msg_ready` and `pl_ready` are 0.
- Simultaneous events: a tail transfer and the next descriptor handshake in the same cycle are legal. The head flit of the next packet is valid the following cycle.
- Reset asserted mid-packet: state returns to IDLE and `valid_out` drops immediately. The partial packet is truncated with no tail; the downstream mesh is reset on the same `rst`.

## Timing
Reset values:
- `data_out` = 0, `valid_out` = 0, `busy` = 0, `pkt_count` = 0.
- `msg_ready` = 0 and `pl_ready` = 0 while reset is asserted.
- `msg_ready` = 1 in the first cycle after deassertion.

Latency and throughput:
- Descriptor handshake at edge T: head flit valid after edge T.
- Payload handshake at edge T: the corresponding flit is valid after edge T.
- With `ready_out` held at 1 and payload always available, a len-N packet occupies N+1 consecutive cycles.
- Back-to-back packets have zero idle cycles between them.

Combinational paths:
- `msg_ready` and `pl_ready` depend combinationally on `ready_out`.
- There is no combinational path from `msg_valid`/`pl_valid` to `valid_out` or `data_out`.

## Configuration
- `NOC_PKT_STATS_EN` defined:
  - Adds the `pkt_count` port: a 16-bit count of tail-flit transfers (`valid_out && ready_out && data_out[31:30] == 2'b11`).
  - Wraps from 0xFFFF to 0.
  - Cleared by `rst`.
- `NOC_PKT_STATS_EN` undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: `rst` = 0 for 2 cycles, then released.
  - Required: `data_out`, `valid_out` and `busy` are 0 throughout reset; `msg_ready` = 1 one cycle after release.
- Basic packet:
  - Stimulus: SRC_ID = 0, dest = 7, len = 5, payloads 0x12–0x16, `ready_out` = 1.
  - Required, on 6 consecutive cycles: 0x40000007, 0x80000012, 0x80000013, 0x80000014, 0x80000015, 0xC0000016.
- Single-word packet:
  - Stimulus: dest = 5, len = 1, payload 0x21.
  - Required: 0x40000005, then 0xC0000021. Stimulus with len = 0 gives the identical output.
- Backpressure:
  - Stimulus: `ready_out` toggling 1,0,0,1 during an 8-word packet.
  - Required: `data_out` stable while stalled; exactly 9 flits transferred; no duplicated or lost flits.
- Back-to-back packets:
  - Stimulus: (dest = 8, len = 3) then (dest = 3, len = 2), with `msg_valid` and `pl_valid` always high.
  - Required: 0xC00000xx tail immediately followed by 0x40000003 head with no gap; 7 flits in 7 cycles.
- Reset mid-packet:
  - Stimulus: `rst` asserted after the 2nd body flit, then released, then a new len = 2 packet.
  - Required: `valid_out` falls immediately at reset; the new packet is clean.
  - With `NOC_PKT_STATS_EN`, `pkt_count` reads 1 (the truncated packet is not counted).
